pointwise_stream_out: RTL

- Output stage directly downstream of the 16-bit pointwise multiply datapath.
- Accepts one result word per cycle over a valid/ready handshake and buffers it in a 2-entry skid FIFO.
- Tracks image raster position and emits end-of-line and end-of-frame markers to the memory writeback/stream sink.
- Decouples the combinational compute path from sink backpressure.

---
 rtl/pointwise_stream_out.sv | 91 +++++++++
 1 files changed

// File: rtl/pointwise_stream_out.sv
// Output stage for the pointwise multiply datapath.
// Provides a 2-entry skid FIFO with a valid/ready handshake on both sides.
// Tracks raster position so it can tag end-of-line and end-of-frame.
// Emits a registered frame_done pulse once the last pixel of a frame has been accepted.
module pointwise_stream_out #(
  parameter int WIDTH = 16,
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_eol,
  output logic             out_eof,
  input  logic             out_ready,
  output logic             frame_done
);

  // Keep the counters at least 1 bit wide, so IMG_W=1 or IMG_H=1 still elaborates.
  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

  // ent0 is always the head; ent1 holds the second word when count==2.
  logic [WIDTH-1:0] ent0, ent1;
  logic [1:0]       count;
  logic [XW-1:0]    x;
  logic [YW-1:0]    y;
  logic             push, pop;

  // Both ready and valid come only from registered count.
  // out_ready therefore never reaches in_ready combinationally.
  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = ent0;
  assign out_eol   = out_valid & (x == X_LAST);
  assign out_eof   = out_eol & (y == Y_LAST);

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Skid FIFO storage and occupancy; a pop shifts ent1 forward into the head slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent0  <= '0;
      ent1  <= '0;
      count <= 2'd0;
    end else begin
      unique case ({push, pop})
        2'b11: ent0 <= in_data;          // only reachable at count==1
        2'b10: begin
          if (count == 2'd0) ent0 <= in_data;
          else               ent1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          ent0  <= ent1;
          count <= count - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Raster position of the head word; it advances only when the sink takes a word.
  always_ff @(posedge clk) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else if (pop) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Pulse for one cycle after the frame's last pixel leaves.
  always_ff @(posedge clk) begin
    if (reset) frame_done <= 1'b0;
    else       frame_done <= pop & out_eof;
  end

endmodule
